// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive side of a time-division multiplexed channel stream. Each valid beat
// on the single input lane carries one slot word; a start-of-frame marker
// identifies slot 0. Each word is steered into its own per-channel output
// register, and that channel's valid pulses one cycle after the beat.
// A start-of-frame that arrives before the current frame is complete is
// flagged as a short frame and begins a new frame.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_sof / in_data are meaningful this cycle
//   in_sof     : start of frame; this beat is slot 0
//   in_data    : slot word
//   out_data   : channel k occupies bits [k*WIDTH +: WIDTH]
//   out_valid  : one-cycle pulse on bit k when channel k is updated
//   frame_done : one-cycle pulse when the last slot is captured
//   frame_err  : one-cycle pulse when a new SOF aborts an incomplete frame
//   slot       : next slot index expected
// -----------------------------------------------------------------------------
module tdm_demux #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic [SEL_W-1:0]          slot
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [SEL_W-1:0]  slot_reg;
    logic [SEL_W-1:0]  slot_next;
    logic              frame_done_reg;
    logic              frame_done_next;
    logic              frame_err_reg;
    logic              frame_err_next;

    // Single write port shared by all channel registers: at most one channel
    // is written per beat, which also guarantees a one-hot out_valid.
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;

    logic [WIDTH-1:0]  data_reg [CHANNELS];
    logic [CHANNELS-1:0] out_valid_reg;

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            slot_reg       <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Next-state and write steering
    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        wr_en           = 1'b0;
        wr_sel          = '0;

        unique case (state_reg)
            IDLE: begin
                // Words outside a frame are dropped silently.
                if (in_valid && in_sof) begin
                    wr_en      = 1'b1;
                    wr_sel     = '0;
                    slot_next  = SLOT_ONE;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Short frame: flag it and restart at slot 0. Slots
                        // not reached in the aborted frame keep old data.
                        frame_err_next = 1'b1;
                        wr_en          = 1'b1;
                        wr_sel         = '0;
                        slot_next      = SLOT_ONE;
                    end else begin
                        wr_en  = 1'b1;
                        wr_sel = slot_reg;
                        if (slot_reg == LAST_SLOT) begin
                            frame_done_next = 1'b1;
                            slot_next       = '0;
                            state_next      = IDLE;
                        end else begin
                            slot_next = slot_reg + SLOT_ONE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                slot_next  = '0;
            end
        endcase
    end

    // Per-channel capture registers and valid pulses
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi]      <= '0;
                    out_valid_reg[gi] <= 1'b0;
                end else begin
                    out_valid_reg[gi] <= wr_en && (wr_sel == SEL_W'(gi));
                    if (wr_en && (wr_sel == SEL_W'(gi))) begin
                        data_reg[gi] <= in_data;
                    end
                end
            end
            assign out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
        end
    endgenerate

    assign out_valid  = out_valid_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign slot       = slot_reg;

endmodule
